// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: arbitrates three pixel-plotting requesters onto a single
// VGA adapter pixel port. Grants are held until the owner drops req or the
// hold limit expires; every release is followed by a one-cycle gap.
// Optional macro VGA_ARB_RR_EN selects round-robin arbitration; without it,
// arbitration is fixed priority (requester 0 highest).
module vga_plot_arbiter #(
  parameter int unsigned MAX_HOLD = 19200,
  parameter int unsigned XMAX     = 160,
  parameter int unsigned YMAX     = 120
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_colour,
  input  logic [2:0]  req_plot,
  output logic [2:0]  gnt,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        timeout
);

  localparam int unsigned     HW        = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    mask_q, mask_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [2:0]    vga_col_q, vga_col_d;
  logic          vga_plot_q, vga_plot_d;

  // Granted requester's signals
  logic          g_req;
  logic          g_plot;
  logic [7:0]    g_x;
  logic [6:0]    g_y;
  logic [2:0]    g_col;
  logic          g_in_range;

  // Arbitration
  logic [2:0]    elig;
  logic [1:0]    search_base;
  logic [1:0]    cand;
  logic          pick_vld;
  logic [1:0]    pick_idx;

  function automatic logic [1:0] inc3(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

`ifdef VGA_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  assign search_base = ptr_q;

  // Round-robin pointer advances past each new grantee
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && pick_vld) begin
      ptr_d = inc3(pick_idx);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign search_base = 2'd0;
`endif

  // Route the currently granted requester's bus onto a single set of wires
  always_comb begin
    g_req  = 1'b0;
    g_plot = 1'b0;
    g_x    = '0;
    g_y    = '0;
    g_col  = '0;
    case (sel_q)
      2'd0: begin
        g_req  = req[0];
        g_plot = req_plot[0];
        g_x    = req_x[7:0];
        g_y    = req_y[6:0];
        g_col  = req_colour[2:0];
      end
      2'd1: begin
        g_req  = req[1];
        g_plot = req_plot[1];
        g_x    = req_x[15:8];
        g_y    = req_y[13:7];
        g_col  = req_colour[5:3];
      end
      2'd2: begin
        g_req  = req[2];
        g_plot = req_plot[2];
        g_x    = req_x[23:16];
        g_y    = req_y[20:14];
        g_col  = req_colour[8:6];
      end
      default: begin
        g_req  = 1'b0;
      end
    endcase
  end

  assign g_in_range = (32'(g_x) < XMAX) && (32'(g_y) < YMAX);

  // Pick the first eligible requester, scanning upward from the search base
  // with wrap 2->0; a base of 0 degenerates to fixed priority.
  always_comb begin
    elig     = req & ~mask_q;
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    cand     = search_base;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
      cand = inc3(cand);
    end
  end

  // FSM next state, grant, hold counter, timeout and mask
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    // A low req always clears that requester's mask bit
    mask_d    = mask_q & req;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_GRANT;
          sel_d   = pick_idx;
          gnt_d   = 3'b001 << pick_idx;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        hold_d = hold_q + 1'b1;
        // A voluntary release wins over an expiring hold in the same cycle
        if (!g_req) begin
          state_d = S_GAP;
          gnt_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d        = S_GAP;
          gnt_d          = '0;
          timeout_d      = 1'b1;
          mask_d[sel_q]  = 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Registered pixel port: follows the grantee in GRANT, holds otherwise
  always_comb begin
    vga_x_d    = vga_x_q;
    vga_y_d    = vga_y_q;
    vga_col_d  = vga_col_q;
    vga_plot_d = 1'b0;
    if (state_q == S_GRANT) begin
      vga_x_d    = g_x;
      vga_y_d    = g_y;
      vga_col_d  = g_col;
      vga_plot_d = g_req && g_plot && g_in_range;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      sel_q      <= 2'd0;
      hold_q     <= '0;
      mask_q     <= '0;
      timeout_q  <= 1'b0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      vga_col_q  <= '0;
      vga_plot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      mask_q     <= mask_d;
      timeout_q  <= timeout_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      vga_col_q  <= vga_col_d;
      vga_plot_q <= vga_plot_d;
    end
  end

  assign gnt        = gnt_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_col_q;
  assign vga_plot   = vga_plot_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 19200, meaning the maximum number of consecutive GRANT cycles for one requester before forced release.
REQ-002 The block SHALL have parameter XMAX, default 160, meaning the exclusive upper bound on plotted x.
REQ-003 The block SHALL have parameter YMAX, default 120, meaning the exclusive upper bound on plotted y.
REQ-004 The block SHALL have port CLOCK_50, input, width 1: the system clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: reset, synchronous, active-low.
REQ-006 The block SHALL have port req, input, width 3: per-requester bus request, bit i for requester i.
REQ-007 The block SHALL have port req_x, input, width 24: requester i x coordinate on bits [8i+7:8i].
REQ-008 The block SHALL have port req_y, input, width 21: requester i y coordinate on bits [7i+6:7i].
REQ-009 The block SHALL have port req_colour, input, width 9: requester i colour on bits [3i+2:3i].
REQ-010 The block SHALL have port req_plot, input, width 3: per-requester pixel-write strobe.
REQ-011 The block SHALL have port gnt, output, width 3: one-hot grant, or all zero.
REQ-012 The block SHALL have ports vga_x (output, 8), vga_y (output, 7), vga_colour (output, 3) and vga_plot (output, 1), forming the pixel port to the VGA adapter.
REQ-013 The block SHALL have port busy, output, width 1: high when the state is not IDLE.
REQ-014 The block SHALL have port timeout, output, width 1: a one-cycle pulse on a forced release.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-016 In IDLE, if any eligible req is high, the block SHALL register the selected index, set gnt and enter GRANT on the next edge, giving 1 cycle of latency from req to gnt.
REQ-017 A requester SHALL be eligible when its req bit is high and its timeout mask bit is clear.
REQ-018 In GRANT, gnt SHALL stay constant until one of the following: req[g] is sampled low, which goes to GAP; or the hold counter reaches MAX_HOLD-1, which goes to GAP, pulses timeout and sets mask[g].
REQ-019 In GAP, gnt SHALL be 0 and vga_plot SHALL be 0 for exactly 1 cycle, after which the FSM enters IDLE.
REQ-020 The hold counter SHALL clear on entry to GRANT and increment on each GRANT cycle, with width ceil(log2(MAX_HOLD))+1.
REQ-021 The mask bit for a requester SHALL clear in any cycle where that requester's req is low.
REQ-022 The pixel outputs SHALL be registered, with a latency of 1 cycle from the granted requester's inputs.
REQ-023 On each edge, vga_plot SHALL be set to the AND of: state==GRANT, req[g], req_plot[g], x<XMAX and y<YMAX.
REQ-024 vga_x, vga_y and vga_colour SHALL follow the granted requester's values while in GRANT and SHALL hold their last value otherwise.
REQ-025 Out-of-range coordinates SHALL be silently dropped, with vga_plot=0 and no state effect.
REQ-026 Plot strobes from non-granted requesters SHALL be ignored.
REQ-027 If req[g] drops in the same cycle that the hold counter expires, the block SHALL treat it as a normal release: no timeout pulse and no mask set.
REQ-028 Requests arriving during GRANT or GAP SHALL wait, with no queueing beyond the level of req.

Reset
REQ-029 While rst_n is low at a clock edge, the block SHALL set state=IDLE, gnt=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, timeout=0, mask=0, hold counter=0 and RR pointer=0.
REQ-030 On reset asserted mid-GRANT, the block SHALL drop the grant in the same edge and emit no timeout pulse.

Configuration
REQ-031 With macro VGA_ARB_RR_EN defined, selection in IDLE SHALL be round-robin: search starts at the pointer, wrapping 2->0, and the pointer becomes g+1 mod 3 on each grant.
REQ-032 Without VGA_ARB_RR_EN, selection SHALL be fixed priority, with requester 0 highest, then 1, then 2, and no pointer register SHALL exist.

Verification
REQ-033 The bench SHALL check that, after reset, with req=3'b010 asserted at cycle 0, gnt=3'b010 at cycle 1 and busy=1.
REQ-034 The bench SHALL check that, with requester 1 granted and req_x=200, req_y=10, req_plot=1, vga_plot=0; and that with req_x=159, req_y=119, vga_plot=1 one cycle later with vga_x=159 and vga_y=119.
REQ-035 The bench SHALL check that, with req=3'b111 held and each grantee releasing after 4 cycles, the grant order is 0,1,2,0 with VGA_ARB_RR_EN and 0,0,0 without it, with a 1-cycle GAP (gnt=0, vga_plot=0) between grants.
REQ-036 The bench SHALL check that, with MAX_HOLD=8 and requester 2 holding req high, timeout pulses once after 8 GRANT cycles, requester 2 is not regranted until its req has been low for at least 1 cycle, and requester 0 is granted in the interim.
REQ-037 The bench SHALL check that asserting rst_n=0 for 1 cycle in mid-GRANT while req_plot=1 gives gnt=0, vga_plot=0 and timeout=0 on the next cycle, and that the FSM is in IDLE.
